mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bit width of each data input and of the output.
REQ-002 The block SHALL have parameter MAX_HOLD, default 15: maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req0, input, 1 bit: request from requester 0.
REQ-006 The block SHALL have port req1, input, 1 bit: request from requester 1.
REQ-007 The block SHALL have port done, input, 1 bit: the current grantee releases the shared path.
REQ-008 The block SHALL have port d0, input, WIDTH bits: data from requester 0.
REQ-009 The block SHALL have port d1, input, WIDTH bits: data from requester 1.
REQ-010 The block SHALL have port gnt0, output, 1 bit: grant to requester 0 (registered).
REQ-011 The block SHALL have port gnt1, output, 1 bit: grant to requester 1 (registered).
REQ-012 The block SHALL have port sel, output, 1 bit: select for the shared 2:1 mux (registered).
REQ-013 The block SHALL have port y, output, WIDTH bits: muxed data, d1 when sel=1, else d0.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever either grant is active.
REQ-015 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-016 The FSM SHALL have exactly three states:
- IDLE: gnt0=gnt1=0, sel=0.
- GNT0: gnt0=1, sel=0.
- GNT1: gnt1=1, sel=1.
REQ-017 Grant latency SHALL be one cycle: a request sampled in IDLE produces a grant on the next edge.
REQ-018 In IDLE, if only one request is high, the FSM SHALL grant that requester.
REQ-019 In IDLE, if both requests are high, the FSM SHALL grant the requester that was not served last.
REQ-020 A 1-bit last-served pointer SHALL update on every grant.
REQ-021 A release event SHALL occur when the grantee's request is low, or done=1, while in GNTx.
REQ-022 On a release event, the next state SHALL be the other GNT state if the other request is high; otherwise IDLE.
REQ-023 The releasing requester SHALL never be re-granted on the release edge.
REQ-024 Requests arriving for the non-granted requester during a grant SHALL be held off; no preemption is allowed, except per REQ-031.
REQ-025 y SHALL be combinational from sel, d0 and d1; y SHALL NOT depend on the grants.
REQ-026 busy SHALL equal gnt0 | gnt1.
REQ-027 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL enter IDLE and set gnt0=gnt1=sel=timeout=0, last-served=1 (so req0 wins the first tie), and hold counter=0.
REQ-029 A reset asserted during a grant SHALL drop the grant at that edge; done is ignored while rst=1.

Configuration
REQ-030 The macro ARB_TIMEOUT_EN SHALL compile in the hold timeout.
REQ-031 With ARB_TIMEOUT_EN defined:
- A hold counter SHALL clear on each grant edge and increment each cycle in GNTx.
- When the counter reaches MAX_HOLD-1 and the other request is high, the FSM SHALL force a release to the other GNT state.
- timeout SHALL pulse for exactly that one cycle (registered, coincident with the new grant).
- If the other request is low at that point, the counter SHALL saturate and the grant SHALL continue.
REQ-032 Without ARB_TIMEOUT_EN, the counter logic SHALL be absent, timeout SHALL be tied to 0, and MAX_HOLD SHALL be unused.

Structure
REQ-033 Shared package mux_arb_pkg SHALL hold the state enum typedef (IDLE, GNT0, GNT1) and the default WIDTH and MAX_HOLD constants.
REQ-034 The hold counter SHALL be a sub-module mux_arb_hold_cnt, instantiated only under ARB_TIMEOUT_EN.
REQ-035 The mux and the FSM SHALL remain in mux_arbiter.

Verification
REQ-036 Reset then req0=req1=1 in the same cycle -> gnt0=1 next cycle, sel=0, y=d0.
REQ-037 Grant to 0, then done=1 with req1=1 -> next edge gnt0=0, gnt1=1, sel=1, y=d1, with no IDLE cycle between.
REQ-038 req0 held high continuously, req1 pulsed repeatedly, done every 3 cycles -> grants strictly alternate 0,1,0,1; gnt0 and gnt1 never overlap.
REQ-039 rst=1 asserted mid-GNT1 -> next edge busy=0, sel=0; after rst=0 with both requests high -> gnt0 first.
REQ-040 ARB_TIMEOUT_EN, MAX_HOLD=4, req0 held with done=0 and req1=1 -> gnt0 lasts exactly 4 cycles, then gnt1=1 with timeout=1 for one cycle.
REQ-041 ARB_TIMEOUT_EN, MAX_HOLD=4, req1=0 -> gnt0 persists past 4 cycles with timeout=0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and default constants for the two-requester mux arbiter.
package mux_arb_pkg;

  localparam int unsigned WIDTH_DEFAULT    = 8;
  localparam int unsigned MAX_HOLD_DEFAULT = 15;
  localparam int unsigned CNT_W            = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Grant hold counter: clears on each new grant, counts while granted,
// saturates at MAX_HOLD-1 and flags that limit.
module mux_arb_hold_cnt
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_max_c
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_max_c = (cnt == LIMIT);

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester arbiter driving a shared 2:1 mux, round-robin on ties.
// Define ARB_TIMEOUT_EN to bound a grant to MAX_HOLD cycles when contended.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEFAULT,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             done,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             timeout
);

  if ((MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("mux_arbiter: MAX_HOLD must be in 1..255");
  end

  arb_state_t state;
  logic       last;     // 1: requester 1 was served most recently
  logic       go0_c;
  logic       go1_c;
  logic       force_c;

  // Next-grant decision; a releasing requester can only hand over or idle.
  always_comb begin
    go0_c = 1'b0;
    go1_c = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last)) begin
          go0_c = 1'b1;
        end else if (req1) begin
          go1_c = 1'b1;
        end
      end
      GNT0: begin
        if (!req0 || done || force_c) begin
          go1_c = req1;
        end else begin
          go0_c = 1'b1;
        end
      end
      GNT1: begin
        if (!req1 || done || force_c) begin
          go0_c = req0;
        end else begin
          go1_c = 1'b1;
        end
      end
      default: begin
        go0_c = 1'b0;
        go1_c = 1'b0;
      end
    endcase
  end

  // State register and registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      sel   <= 1'b0;
      busy  <= 1'b0;
      last  <= 1'b1;
    end else begin
      if (go0_c) begin
        state <= GNT0;
      end else if (go1_c) begin
        state <= GNT1;
      end else begin
        state <= IDLE;
      end
      gnt0 <= go0_c;
      gnt1 <= go1_c;
      sel  <= go1_c;
      busy <= go0_c | go1_c;
      if (go0_c) begin
        last <= 1'b0;
      end else if (go1_c) begin
        last <= 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic at_max_c;
  logic grant_edge_c;
  logic timeout_q;

  assign grant_edge_c = (go0_c && (state != GNT0)) || (go1_c && (state != GNT1));

  // Forced handover only when the grantee would otherwise keep the path.
  assign force_c = at_max_c &&
                   (((state == GNT0) && req0 && !done && req1) ||
                    ((state == GNT1) && req1 && !done && req0));

  mux_arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (grant_edge_c),
    .en       (state != IDLE),
    .at_max_c (at_max_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_c;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_c = 1'b0;
  assign timeout = 1'b0;
`endif

  assign y = sel ? d1 : d0;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboarded directed/random bench for mux_arbiter (MAX_HOLD=4).
module tb_mux_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic         gnt0;
    logic         gnt1;
    logic         sel;
    logic         busy;
    logic         timeout;
    logic [W-1:0] y;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         req0;
  logic         req1;
  logic         done;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic         gnt0;
  logic         gnt1;
  logic         sel;
  logic [W-1:0] y;
  logic         busy;
  logic         timeout;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  // Reference model: 0 idle, 1 granted to 0, 2 granted to 1
  int m_state = 0;
  bit m_last  = 1'b1;
  int m_cnt   = 0;

  mux_arbiter #(
    .WIDTH    (W),
    .MAX_HOLD (MH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .done    (done),
    .d0      (d0),
    .d1      (d1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .sel     (sel),
    .y       (y),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare.
  task automatic step(input bit r0, input bit r1, input bit dn, input bit rs);
    exp_t e;
    int   ns;
    bit   to;
    bit   rel;
    bit   frc;
    req0 = r0;
    req1 = r1;
    done = dn;
    rst  = rs;
    d0   = W'($urandom);
    d1   = W'($urandom);
    ns   = m_state;
    to   = 1'b0;
    if (rs) begin
      ns     = 0;
      m_last = 1'b1;
      m_cnt  = 0;
    end else begin
      case (m_state)
        1: begin
          rel = !r0 || dn;
          frc = TO_EN && (m_cnt >= int'(MH) - 1) && r1;
          if (rel || frc) begin
            ns = r1 ? 2 : 0;
            to = frc && !rel;
          end
        end
        2: begin
          rel = !r1 || dn;
          frc = TO_EN && (m_cnt >= int'(MH) - 1) && r0;
          if (rel || frc) begin
            ns = r0 ? 1 : 0;
            to = frc && !rel;
          end
        end
        default: begin
          if (r0 && r1) ns = m_last ? 1 : 2;
          else if (r0) ns = 1;
          else if (r1) ns = 2;
          else ns = 0;
        end
      endcase
      if (ns != 0 && ns != m_state) m_cnt = 0;
      else if (ns != 0 && m_cnt < int'(MH) - 1) m_cnt++;
      if (ns == 1) m_last = 1'b0;
      else if (ns == 2) m_last = 1'b1;
    end
    m_state   = ns;
    e.gnt0    = (ns == 1);
    e.gnt1    = (ns == 2);
    e.sel     = (ns == 2);
    e.busy    = (ns != 0);
    e.timeout = to;
    e.y       = (ns == 2) ? d1 : d0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("gnt0", 32'(gnt0), 32'(e.gnt0));
    check("gnt1", 32'(gnt1), 32'(e.gnt1));
    check("sel", 32'(sel), 32'(e.sel));
    check("busy", 32'(busy), 32'(e.busy));
    check("timeout", 32'(timeout), 32'(e.timeout));
    check("y", 32'(y), 32'(e.y));
    check("exclusive", 32'(gnt0 & gnt1), 32'd0);
  endtask

  initial begin
    bit prev_busy;
    bit prev_owner;
    bit have_prev;
    bit still0;
    int run;
    int pulses;

    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    done = 1'b0;
    d0   = '0;
    d1   = '0;

    step(0, 0, 0, 1);
    step(1, 1, 1, 1);
    check("reset_busy", 32'(busy), 32'd0);

    // Tie right after reset goes to requester 0
    step(1, 1, 0, 0);
    check("tie_gnt0", 32'(gnt0), 32'd1);
    check("tie_y_d0", 32'(y), 32'(d0));

    // done with req1 waiting hands over without an idle cycle
    step(1, 1, 1, 0);
    check("handover_gnt1", 32'(gnt1), 32'd1);
    check("handover_y_d1", 32'(y), 32'(d1));
    step(0, 0, 1, 0);

    // req0 steady, req1 pulsed, done every 3 cycles: strict alternation
    prev_busy  = 1'b0;
    prev_owner = 1'b0;
    have_prev  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, (i % 3) != 2, (i % 3) == 1, 1'b0);
      if (busy && (!prev_busy || (gnt1 != prev_owner))) begin
        if (have_prev) check("alternate", 32'(gnt1), 32'(!prev_owner));
        prev_owner = gnt1;
        have_prev  = 1'b1;
      end
      prev_busy = busy;
    end
    step(0, 0, 0, 0);

    // Reset in the middle of a grant to requester 1
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 1);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_sel", 32'(sel), 32'd0);
    step(1, 1, 0, 0);
    check("postreset_gnt0", 32'(gnt0), 32'd1);
    step(0, 0, 0, 0);

    // Uncontended grant is never cut short
    run = 0;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0, 0);
      if (gnt0) run++;
      if (timeout) pulses++;
    end
    check("solo_run", 32'(run), 32'd7);
    check("solo_pulses", 32'(pulses), 32'd0);
    step(0, 0, 0, 0);

    // Contended grant held by requester 0 with done low
    step(1, 0, 0, 0);
    run    = gnt0 ? 1 : 0;
    pulses = 0;
    still0 = gnt0;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0);
      if (still0 && gnt0) run++;
      else still0 = 1'b0;
      if (timeout) pulses++;
    end
`ifdef ARB_TIMEOUT_EN
    check("contend_run", 32'(run), 32'd4);
    check("contend_pulses", 32'(pulses), 32'd1);
`else
    check("contend_run", 32'(run), 32'd7);
    check("contend_pulses", 32'(pulses), 32'd0);
`endif
    step(0, 0, 0, 0);

    // Random traffic with occasional reset
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
